// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI initiator.
// Optional feature macro: SPI_MASTER_LSB_FIRST_EN.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } spi_state_e;

    localparam int SPI_WIDTH  = 8;
    localparam int SPI_CLKDIV = 4;

endpackage

// File: rtl/spi_edge_gen.sv
// Half-period timer: alternating rise/fall pulses every CLKDIV cycles
// while enabled; held cleared while disabled.
import spi_pkg::*;

module spi_edge_gen #(
    parameter int CLKDIV = SPI_CLKDIV
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic riseEdge,
    output logic fallEdge
);

    localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          tick;

    always_comb begin
        tick    = enable && (cnt_q == CW'(CLKDIV - 1));
        cnt_d   = '0;
        phase_d = 1'b0;
        if (enable) begin
            cnt_d   = tick ? '0 : cnt_q + 1'b1;
            phase_d = phase_q ^ tick;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // phase low means sclk is currently low, so the next tick is a rise
    assign riseEdge = tick & ~phase_q;
    assign fallEdge = tick & phase_q;

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: FSM, bit counter, shift registers, output flops.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first transfers.
import spi_pkg::*;

module spi_master #(
    parameter int WIDTH  = SPI_WIDTH,
    parameter int CLKDIV = SPI_CLKDIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] txData,
    input  logic             miso,
    output logic [WIDTH-1:0] rxData,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             cs,
    output logic             mosi
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    spi_state_e       state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] rxd_q, rxd_d;
    logic             mosi_q, mosi_d;
    logic             sclk_q, sclk_d;
    logic             cs_q, cs_d;
    logic             done_q, done_d;
    logic             rise, fall;
    logic [WIDTH-1:0] tx_sh, rx_sh;

`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam int MB = 0;
    assign tx_sh = tx_q >> 1;
    assign rx_sh = {miso, rx_q[WIDTH-1:1]};
`else
    localparam int MB = WIDTH - 1;
    assign tx_sh = tx_q << 1;
    assign rx_sh = {rx_q[WIDTH-2:0], miso};
`endif

    spi_edge_gen #(.CLKDIV(CLKDIV)) u_edge (
        .clk     (clk),
        .reset   (reset),
        .enable  (state_q != IDLE),
        .riseEdge(rise),
        .fallEdge(fall)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rxd_d   = rxd_q;
        mosi_d  = mosi_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOW;
                    tx_d    = txData;
                    rx_d    = '0;
                    bit_d   = '0;
                    cs_d    = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = txData[MB];
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                    sclk_d  = 1'b1;
                    rx_d    = rx_sh;
                end
            end
            HIGH: begin
                if (fall) begin
                    sclk_d = 1'b0;
                    if (bit_q == BW'(WIDTH - 1)) begin
                        state_d = IDLE;
                        cs_d    = 1'b1;
                        done_d  = 1'b1;
                        rxd_d   = rx_q;
                    end else begin
                        state_d = LOW;
                        bit_d   = bit_q + 1'b1;
                        tx_d    = tx_sh;
                        mosi_d  = tx_sh[MB];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rxd_q   <= '0;
            mosi_q  <= 1'b0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rxd_q   <= rxd_d;
            mosi_q  <= mosi_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            done_q  <= done_d;
        end
    end

    assign rxData = rxd_q;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign sclk   = sclk_q;
    assign cs     = cs_q;
    assign mosi   = mosi_q;

endmodule
